// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot/fetch front end:
// phase encoding, default address width and the filler word returned
// for misaligned fetches.
package imem_pkg;

  // Byte address width of the instruction memory (2 KiB).
  localparam int IMEM_ADDR_W = 11;

  // Word returned when a fetch address is not word aligned (addi x0,x0,0).
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Operating phase of the arbiter.
  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  // True when the low two address bits do not select a word boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/imem_boot_arbiter.sv
// Owner of the single instruction-memory port. After reset it streams
// loader bytes into memory (fetch stalled). Once the image is complete it
// serves word fetches with a registered one-cycle response. A reload pulse
// returns it to the loading phase.
module imem_boot_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ld_valid,
  input  logic [7:0]        i_ld_byte,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  input  logic              i_reload,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_valid,
  output logic [31:0]       o_fetch_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_boot_done,
  output logic [ADDR_W:0]   o_ld_count,
  output logic              o_misalign
);

  imem_state_e       state_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W:0]   ld_count_r;
  logic              fetch_valid_r;
  logic [31:0]       fetch_data_r;
  logic              misalign_r;
  logic              boot_done_r;

  logic              ld_ready_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [7:0]        mem_wdata_s;
  logic              ld_fire_s;
  logic              ld_final_s;

  // A loader byte is committed only in LOAD and only when no reload wins the cycle.
  always_comb begin
    ld_fire_s  = 1'b0;
    ld_final_s = 1'b0;
    if (state_r == ST_LOAD && i_ld_valid && !i_reload) begin
      ld_fire_s  = 1'b1;
      ld_final_s = i_ld_last || (wr_ptr_r == {ADDR_W{1'b1}});
    end else begin
      ld_fire_s  = 1'b0;
      ld_final_s = 1'b0;
    end
  end

  // Memory port mux: loader owns the port in LOAD, fetch address drives it in RUN.
  always_comb begin
    ld_ready_s  = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = 8'h00;
    case (state_r)
      ST_LOAD: begin
        ld_ready_s  = 1'b1;
        mem_addr_s  = wr_ptr_r;
        mem_wdata_s = i_ld_byte;
        mem_we_s    = ld_fire_s;
      end
      ST_RUN: begin
        ld_ready_s  = 1'b0;
        mem_addr_s  = i_fetch_addr;
        mem_wdata_s = 8'h00;
        mem_we_s    = 1'b0;
      end
      default: begin
        ld_ready_s  = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = 8'h00;
        mem_we_s    = 1'b0;
      end
    endcase
  end

  // Phase FSM with registered boot status, load counters and fetch response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= ST_LOAD;
      wr_ptr_r      <= {ADDR_W{1'b0}};
      ld_count_r    <= {(ADDR_W+1){1'b0}};
      fetch_valid_r <= 1'b0;
      fetch_data_r  <= 32'h0000_0000;
      misalign_r    <= 1'b0;
      boot_done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          // Fetch is stalled while loading; requests are dropped, not queued.
          fetch_valid_r <= 1'b0;
          if (i_reload) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            ld_count_r <= {(ADDR_W+1){1'b0}};
          end else if (ld_fire_s) begin
            wr_ptr_r   <= wr_ptr_r + ADDR_W'(1);
            ld_count_r <= ld_count_r + (ADDR_W+1)'(1);
            if (ld_final_s) begin
              state_r     <= ST_RUN;
              boot_done_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_reload) begin
            // Reload beats any same-cycle fetch.
            state_r       <= ST_LOAD;
            boot_done_r   <= 1'b0;
            wr_ptr_r      <= {ADDR_W{1'b0}};
            ld_count_r    <= {(ADDR_W+1){1'b0}};
            misalign_r    <= 1'b0;
            fetch_valid_r <= 1'b0;
          end else begin
            fetch_valid_r <= i_fetch_req;
            if (i_fetch_req) begin
              if (is_misaligned(i_fetch_addr[1:0])) begin
                fetch_data_r <= NOP_WORD;
                misalign_r   <= 1'b1;
              end else begin
                fetch_data_r <= i_mem_rdata;
              end
            end
          end
        end
        default: begin
          state_r       <= ST_LOAD;
          boot_done_r   <= 1'b0;
          fetch_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_ld_ready    = ld_ready_s;
  assign o_mem_we      = mem_we_s;
  assign o_mem_addr    = mem_addr_s;
  assign o_mem_wdata   = mem_wdata_s;
  assign o_fetch_valid = fetch_valid_r;
  assign o_fetch_data  = fetch_data_r;
  assign o_boot_done   = boot_done_r;
  assign o_ld_count    = ld_count_r;
  assign o_misalign    = misalign_r;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Scoreboard bench for imem_boot_arbiter. Stimulus pushes expected memory
// writes and fetch responses (with the cycle they are due) into queues; a
// negedge monitor pops and compares whenever the DUT writes or responds.
module tb_imem_boot_arbiter;

  localparam int AW    = 11;
  localparam int DEPTH = 2048;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_ld_valid = 1'b0;
  logic [7:0]    i_ld_byte = 8'h00;
  logic          i_ld_last = 1'b0;
  logic          o_ld_ready;
  logic          i_reload = 1'b0;
  logic          i_fetch_req = 1'b0;
  logic [AW-1:0] i_fetch_addr = '0;
  logic          o_fetch_valid;
  logic [31:0]   o_fetch_data;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we;
  logic [7:0]    o_mem_wdata;
  logic [31:0]   i_mem_rdata;
  logic          o_boot_done;
  logic [AW:0]   o_ld_count;
  logic          o_misalign;

  imem_boot_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ld_valid(i_ld_valid), .i_ld_byte(i_ld_byte), .i_ld_last(i_ld_last),
    .o_ld_ready(o_ld_ready), .i_reload(i_reload),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_valid(o_fetch_valid), .o_fetch_data(o_fetch_data),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_boot_done(o_boot_done),
    .o_ld_count(o_ld_count), .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  // Memory array outside the DUT: byte writes, combinational wrapping word read.
  logic [7:0]    dut_mem [0:DEPTH-1];
  logic          clr_mem = 1'b1;
  logic [AW-1:0] a1, a2, a3;
  assign a1 = o_mem_addr + 11'd1;
  assign a2 = o_mem_addr + 11'd2;
  assign a3 = o_mem_addr + 11'd3;
  assign i_mem_rdata = {dut_mem[a3], dut_mem[a2], dut_mem[a1], dut_mem[o_mem_addr]};

  always @(posedge i_clk) begin
    if (clr_mem) begin
      for (int k = 0; k < DEPTH; k++) dut_mem[k] <= 8'h00;
    end else if (o_mem_we) begin
      dut_mem[o_mem_addr] <= o_mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t fq[$];
  exp_t wq[$];

  int total = 0;
  int bad = 0;

  // Reference model: image contents and boot status, kept as plain numbers.
  logic [7:0] ref_mem [0:DEPTH-1];
  bit model_run = 0;
  int model_wr = 0;
  int model_count = 0;
  bit model_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {ref_mem[(a + 3) % DEPTH], ref_mem[(a + 2) % DEPTH],
            ref_mem[(a + 1) % DEPTH], ref_mem[a % DEPTH]};
  endfunction

  // Monitor: compare writes and fetch responses against the queued expectations.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_reset) begin
      if (o_fetch_valid) begin
        if (fq.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_unexpected: got data %h expected no response", o_fetch_data);
        end else begin
          e = fq.pop_front();
          chk("fetch_data", o_fetch_data, e.d);
          chk("fetch_cycle", cyc, e.due);
        end
      end else if (fq.size() != 0 && fq[0].due < cyc) begin
        e = fq.pop_front();
        total++; bad++;
        $display("FAIL fetch_missing: got no response expected %h", e.d);
      end
      if (o_mem_we) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL write_unexpected: got addr %h byte %h expected no write", o_mem_addr, o_mem_wdata);
        end else begin
          e = wq.pop_front();
          chk("write_addr_byte", {13'd0, o_mem_addr, o_mem_wdata}, e.d);
        end
      end else if (wq.size() != 0 && wq[0].due < cyc) begin
        e = wq.pop_front();
        total++; bad++;
        $display("FAIL write_missing: got no write expected %h", e.d);
      end
    end
  end

  // One clock of stimulus; the model predicts the outcome from the interface rules.
  task automatic step(input bit v, input logic [7:0] b, input bit last,
                      input bit rl, input bit req, input logic [AW-1:0] addr);
    bit   run_next;
    exp_t e;
    run_next     = model_run;
    i_ld_valid   = v;
    i_ld_byte    = b;
    i_ld_last    = last;
    i_reload     = rl;
    i_fetch_req  = req;
    i_fetch_addr = addr;
    if (!model_run) begin
      if (rl) begin
        model_wr = 0;
        model_count = 0;
      end else if (v) begin
        e.d = {13'd0, model_wr[10:0], b};
        e.due = cyc;
        wq.push_back(e);
        ref_mem[model_wr] = b;
        model_wr++;
        model_count++;
        if (last || model_wr == DEPTH) run_next = 1;
        model_wr = model_wr % DEPTH;
      end
    end else begin
      if (rl) begin
        run_next = 0;
        model_wr = 0;
        model_count = 0;
        model_mis = 0;
      end else if (req) begin
        e.due = cyc + 1;
        if (addr % 4 != 0) begin
          e.d = NOP;
          model_mis = 1;
        end else begin
          e.d = word_at(int'(addr));
        end
        fq.push_back(e);
      end
    end
    @(posedge i_clk);
    #1;
    model_run = run_next;
    i_ld_valid = 1'b0; i_ld_last = 1'b0; i_reload = 1'b0; i_fetch_req = 1'b0;
    chk("boot_done", {31'd0, o_boot_done}, {31'd0, model_run});
    chk("ld_count", {20'd0, o_ld_count}, model_count);
    chk("misalign", {31'd0, o_misalign}, {31'd0, model_mis});
    chk("ld_ready", {31'd0, o_ld_ready}, {31'd0, !model_run});
  endtask

  task automatic fetch(input logic [AW-1:0] addr);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, addr);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ld_ready"}, {31'd0, o_ld_ready}, 32'd1);
    chk({tag, "_mem_we"}, {31'd0, o_mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {21'd0, o_mem_addr}, 32'd0);
    chk({tag, "_fetch_valid"}, {31'd0, o_fetch_valid}, 32'd0);
    chk({tag, "_fetch_data"}, o_fetch_data, 32'd0);
    chk({tag, "_boot_done"}, {31'd0, o_boot_done}, 32'd0);
    chk({tag, "_ld_count"}, {20'd0, o_ld_count}, 32'd0);
    chk({tag, "_misalign"}, {31'd0, o_misalign}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    boot_img [0:7];
    logic [AW-1:0] ra;
    boot_img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;

    // Reset with memory clear.
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    clr_mem = 1'b0;
    i_reset = 1'b0;

    // Fetches while loading are ignored.
    fetch(11'd0);
    fetch(11'd4);

    // Boot image of 8 bytes, last on the 8th.
    for (int k = 0; k < 8; k++) step(1'b1, boot_img[k], k == 7, 1'b0, 1'b0, 11'd0);
    chk("boot8_count", {20'd0, o_ld_count}, 32'd8);
    chk("boot8_done", {31'd0, o_boot_done}, 32'd1);

    // Back-to-back aligned fetches, then misaligned, then aligned again.
    fetch(11'd0);
    fetch(11'd4);
    fetch(11'd2);
    fetch(11'd4);
    fetch(11'd0);
    chk("misalign_sticky", {31'd0, o_misalign}, 32'd1);

    // Reload collides with a fetch: reload wins.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 11'd0);
    chk("reload_state", {31'd0, o_boot_done}, 32'd0);
    chk("reload_misalign", {31'd0, o_misalign}, 32'd0);

    // Randomized mix of loader bytes, reloads and fetches.
    for (int n = 0; n < 400; n++) begin
      ra = 11'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 9) < 7) ra[1:0] = 2'b00;
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), ra);
    end

    // Full memory stream without a last flag.
    if (model_run) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'd0);
    for (int k = 0; k < DEPTH; k++)
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 11'd0);
    chk("full_count", {20'd0, o_ld_count}, 32'd2048);
    chk("full_done", {31'd0, o_boot_done}, 32'd1);
    fetch(11'd2044);
    fetch(11'd2046);
    fetch(11'd1024);
    fetch(11'd0);

    // Asynchronous reset in the middle of a load.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'd0);
    for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 11'd0);
    #1 i_reset = 1'b1;
    #1 check_reset_values("async");
    #1 i_reset = 1'b0;
    model_run = 0; model_wr = 0; model_count = 0; model_mis = 0;
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 11'd0);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 11'd0);
    fetch(11'd0);
    fetch(11'd3);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 11'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 11'd0);

    chk("fetch_queue_drained", fq.size(), 32'd0);
    chk("write_queue_drained", wq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_arbiter.md
# imem_boot_arbiter

Front-end controller that owns the single port of the byte-addressed 2 KiB instruction memory. After reset it runs a boot phase, streaming program bytes from a loader into memory while fetch is stalled. It then switches to run phase, serving word fetches from the core with a registered, one-cycle response. Sits between the loader (UART/testbench byte stream), the fetch stage and the instruction memory array.

## Interface
- ADDR_W, 11: byte address width; memory depth is 2**ADDR_W bytes.
- NOP_WORD, 32'h0000_0013: word returned for misaligned fetches.

- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_ld_valid  in  1  loader byte valid.
- i_ld_byte  in  8  loader byte.
- i_ld_last  in  1  qualifies the final byte of the image.
- o_ld_ready  out  1  loader byte accepted when valid & ready.
- i_reload  in  1  one-cycle pulse; return to boot phase.
- i_fetch_req  in  1  fetch request.
- i_fetch_addr  in  ADDR_W  fetch byte address.
- o_fetch_valid  out  1  registered fetch response valid.
- o_fetch_data  out  32  registered fetch word, little-endian.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_we  out  1  memory byte write enable.
- o_mem_wdata  out  8  memory write byte.
- i_mem_rdata  in  32  combinational word read {m[a+3],m[a+2],m[a+1],m[a]}.
- o_boot_done  out  1  high in RUN.
- o_ld_count  out  ADDR_W+1  bytes written in current boot.
- o_misalign  out  1  sticky: a misaligned fetch occurred since reset/reload.

## Operation
- States: LOAD (reset state), RUN.
- LOAD: o_ld_ready=1. On handshake: o_mem_we=1, o_mem_addr=wr_ptr, o_mem_wdata=i_ld_byte; wr_ptr and o_ld_count increment.
- LOAD -> RUN on handshake with i_ld_last=1, or on handshake writing address 2**ADDR_W-1 (memory full). The remaining bytes stay unchanged.
- LOAD: fetch requests are ignored; o_fetch_valid=0; no queuing.
- RUN: o_ld_ready=0; o_mem_we=0; o_mem_addr=i_fetch_addr. On i_fetch_req, the next cycle gives o_fetch_valid=1 and o_fetch_data=i_mem_rdata sampled at the request edge.
- Misaligned request (addr[1:0]!=0): respond with NOP_WORD and set o_misalign.
- The memory wraps addresses near the top; this block does not check that.
- RUN with i_reload=1 -> LOAD. Clears wr_ptr, o_ld_count and o_misalign. A fetch request in the same cycle is dropped (reload wins); o_fetch_valid=0 next cycle.
- i_reload in LOAD: clears wr_ptr/count, remains LOAD; a same-cycle loader byte is discarded (no write).
- Reset values: state=LOAD, wr_ptr=0, o_ld_count=0, o_fetch_valid=0, o_fetch_data=0, o_misalign=0, o_boot_done=0. Combinational outputs follow LOAD: o_ld_ready=1, o_mem_we=0, o_mem_addr=0.
- Reset mid-load: the partial image remains in memory; the pointer restarts at 0.

## Timing
- Loader throughput: one byte per cycle; write is committed on the handshake edge.
- o_boot_done rises the cycle after the last-byte handshake. A fetch in that cycle is served, and its response appears one cycle later.
- Fetch latency: exactly 1 cycle, fully pipelined, one response per request cycle.
- o_fetch_valid holds for one cycle per request only.
- o_misalign is set in the same edge that registers the NOP response.

## Structure
- Shared package `imem_pkg`: state enum (LOAD, RUN), ADDR_W default, NOP_WORD constant.
- Single module, no sub-modules. The memory array remains a separate instance outside this block.

## Test plan
- Boot: reset, stream bytes 13 00 00 00 93 00 10 00 with last on the 8th byte. Check o_ld_count=8, o_boot_done=1 one cycle later, and 8 write strobes at addresses 0..7.
- Fetch: in RUN, request addr 0 then 4 back-to-back. Expect valid on the next two cycles with data 32'h00000013 then 32'h00100093.
- Misaligned: fetch addr 2. Expect NOP_WORD and o_misalign=1, which stays set through later aligned fetches.
- Stall: fetch requests during LOAD produce no o_fetch_valid. Continuous stream of 2048 bytes without last ends boot at count 2048.
- Reload collision: i_reload with i_fetch_req in RUN. Expect o_fetch_valid=0 next cycle, state LOAD, o_ld_count=0, o_misalign=0.
- Async reset mid-load: assert i_reset between clock edges after 5 bytes. All outputs return to reset values immediately, and the next byte writes address 0.
